// File: rtl/echo_timer.sv
// echo_timer: periodic ultrasonic trigger, echo synchroniser and echo pulse-width timer.
// Publishes one result per period: a width with a valid strobe, or a timeout strobe.
module echo_timer #(
    parameter int TRIG_CYCLES    = 500,
    parameter int PERIOD_CYCLES  = 3_000_000,
    parameter int TIMEOUT_CYCLES = 1_250_000,
    parameter int WIDTH          = 24
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_echo,
    output logic             o_trigger,
    output logic [WIDTH-1:0] o_width,
    output logic             o_width_valid,
    output logic             o_timeout
);
    localparam int PW = $clog2(PERIOD_CYCLES);

    typedef enum logic [1:0] {ARM, WAIT_RISE, MEASURE, DONE} state_t;

    state_t           r_state;
    logic             r_s1, r_s2, r_ed;
    logic [PW-1:0]    r_pcnt;
    logic [WIDTH-1:0] r_mcnt;
    logic [WIDTH-1:0] r_width;
    logic             r_trigger, r_width_valid, r_timeout;
    logic             w_rise;

    assign w_rise        = r_s2 & ~r_ed;
    assign o_trigger     = r_trigger;
    assign o_width       = r_width;
    assign o_width_valid = r_width_valid;
    assign o_timeout     = r_timeout;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_ed      <= 1'b0;
            r_pcnt    <= '0;
            r_trigger <= 1'b0;
        end else begin
            r_s1      <= i_echo;
            r_s2      <= r_s1;
            r_ed      <= r_s2;
            r_pcnt    <= (r_pcnt == PW'(PERIOD_CYCLES - 1)) ? '0 : r_pcnt + PW'(1);
            r_trigger <= r_pcnt < PW'(TRIG_CYCLES);
        end
    end

    // Measurement FSM; the window opens on the edge where the trigger falls.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= ARM;
            r_mcnt        <= '0;
            r_width       <= '0;
            r_width_valid <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_width_valid <= 1'b0;
            r_timeout     <= 1'b0;
            case (r_state)
                ARM: begin
                    if (r_pcnt == PW'(TRIG_CYCLES)) begin
                        r_mcnt  <= '0;
                        r_state <= WAIT_RISE;
                    end
                end
                WAIT_RISE: begin
                    if (w_rise) begin
                        r_mcnt  <= WIDTH'(1);
                        r_state <= MEASURE;
                    end else if (r_mcnt == WIDTH'(TIMEOUT_CYCLES - 1)) begin
                        r_timeout <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_mcnt <= r_mcnt + WIDTH'(1);
                    end
                end
                MEASURE: begin
                    if (!r_s2) begin
                        r_width       <= r_mcnt;
                        r_width_valid <= 1'b1;
                        r_state       <= DONE;
                    end else if (r_mcnt == WIDTH'(TIMEOUT_CYCLES)) begin
                        r_timeout <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_mcnt <= r_mcnt + WIDTH'(1);
                    end
                end
                DONE: begin
                    if (r_pcnt == PW'(PERIOD_CYCLES - 1)) r_state <= ARM;
                end
                default: r_state <= ARM;
            endcase
        end
    end
endmodule

// File: tb/tb_echo_timer.sv
// tb_echo_timer: whole stimulus is pre-built, a pulse-level model predicts every cycle,
// and one compare process checks the DUT against it at each falling edge.
module tb_echo_timer;
    localparam int P  = 200;
    localparam int TR = 5;
    localparam int TO = 40;
    localparam int W  = 8;
    localparam int N  = 3050;

    logic         clk = 1'b0;
    logic         i_reset = 1'b1;
    logic         i_echo = 1'b0;
    logic         o_trigger, o_width_valid, o_timeout;
    logic [W-1:0] o_width;

    bit rst_v [N];
    bit echo_v [N];
    bit trig_e [N];
    bit wv_e [N];
    bit to_e [N];
    int wval [N];
    int width_e [N];

    int n_chk = 0;
    int n_fail = 0;
    int cur = -1;

    echo_timer #(.TRIG_CYCLES(TR), .PERIOD_CYCLES(P), .TIMEOUT_CYCLES(TO), .WIDTH(W)) dut (
        .i_clock(clk), .i_reset(i_reset), .i_echo(i_echo),
        .o_trigger(o_trigger), .o_width(o_width),
        .o_width_valid(o_width_valid), .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, cur, act, exp);
        end
    endtask

    task automatic set_pulse(input int s, input int len);
        for (int j = s; j < s + len; j++) if (j >= 0 && j < N) echo_v[j] = 1'b1;
    endtask

    // Echo level as seen by the timer: samples before the current run's release read as 0.
    function automatic bit samp(input int rb, input int j);
        return (j >= rb && j < N) ? echo_v[j] : 1'b0;
    endfunction

    // One measurement window opened at edge g0 of a run starting at edge rb.
    task automatic measure(input int rb, input int g0);
        bit found, ok;
        int a, n, ev;
        found = 1'b0;
        a = 0;
        for (int e = g0 + 1; e <= g0 + TO; e++)
            if (!found && samp(rb, e - 2) && !samp(rb, e - 3)) begin
                found = 1'b1;
                a = e - 2;
            end
        if (found) begin
            n = 0;
            while (n <= TO && samp(rb, a + n)) n++;
            ev = (n <= TO) ? a + n + 2 : a + 2 + TO;
        end else begin
            n = TO + 1;
            ev = g0 + TO;
        end
        ok = ev < N;
        for (int j = g0 + 1; j <= ev && j < N; j++) if (rst_v[j]) ok = 1'b0;
        if (ok) begin
            if (n <= TO) begin
                wv_e[ev] = 1'b1;
                wval[ev] = n;
            end else begin
                to_e[ev] = 1'b1;
            end
        end
    endtask

    task automatic build_model();
        int rs, k, w;
        rs = -1;
        for (int g = 0; g < N; g++) begin
            if (rst_v[g]) begin
                rs = g;
                trig_e[g] = 1'b0;
            end else begin
                k = g - rs - 1;
                trig_e[g] = (k % P) < TR;
                if (k % P == TR) measure(rs + 1, g);
            end
        end
        w = 0;
        for (int g = 0; g < N; g++) begin
            if (rst_v[g]) w = 0;
            else if (wv_e[g]) w = wval[g];
            width_e[g] = w;
        end
    endtask

    task automatic random_period(input int base);
        int s, len;
        s = base + TR + $urandom_range(0, 54) - 4;
        len = $urandom_range(1, 46);
        set_pulse(s, len);
        if ($urandom_range(0, 1) == 1) set_pulse(s + len + $urandom_range(2, 60), $urandom_range(1, 20));
    endtask

    always @(negedge clk) begin
        if (cur >= 0) begin
            chk("trigger", int'(o_trigger), int'(trig_e[cur]));
            chk("width", int'(o_width), width_e[cur]);
            chk("width_valid", int'(o_width_valid), int'(wv_e[cur]));
            chk("timeout", int'(o_timeout), int'(to_e[cur]));
        end
    end

    initial begin
        // Run starts at edge 3; period p begins at 3+200p, window opens 5 edges later.
        for (int g = 0; g < 3; g++) rst_v[g] = 1'b1;
        set_pulse(218, 23);
        set_pulse(618, 40);
        set_pulse(818, 41);
        set_pulse(1005, 30);
        set_pulse(1073, 12);
        set_pulse(1218, 12);
        set_pulse(1446, 5);
        for (int p = 8; p < 13; p++) random_period(3 + p * P);
        set_pulse(2618, 20);
        rst_v[2628] = 1'b1;
        set_pulse(2629 + 15, 17);
        random_period(2629 + P);
        build_model();
        chk("model trig first", int'(trig_e[3]), 1);
        chk("model trig last", int'(trig_e[7]), 1);
        chk("model trig fall", int'(trig_e[8]), 0);
        chk("model trig period", int'(trig_e[203]), 1);
        chk("model timeout noecho", int'(to_e[48]), 1);
        chk("model valid 23", int'(wv_e[243]), 1);
        chk("model width 23", width_e[243], 23);
        chk("model hold timeout", int'(to_e[448]), 1);
        chk("model hold width", width_e[448], 23);
        chk("model width 40", width_e[660], 40);
        chk("model over timeout", int'(to_e[860]), 1);
        chk("model stale timeout", int'(to_e[1048]), 1);
        chk("model width 12", width_e[1232], 12);
        chk("model rise wins", width_e[1453], 5);
        chk("model reset width", width_e[2628], 0);
        chk("model restart trig", int'(trig_e[2629]), 1);
        chk("model after reset", width_e[2663], 17);
        for (int g = 0; g < N; g++) begin
            i_reset = rst_v[g];
            i_echo = echo_v[g];
            @(posedge clk);
            cur = g;
            @(negedge clk);
        end
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
